latency_data_memory: RTL and testbench

- Parametrised successor to the single-cycle data memory, used behind the cache or multicycle datapath.
- Adds configurable access latency, a valid/ready request handshake, a one-cycle response pulse, wide (line-size) data, byte-strobe writes and out-of-range detection.
- Used as the backing store for cache refill/writeback and for stall testing of the pipelined core.

---
 rtl/memory_pkg.sv | 17 +
 rtl/mem_latency_counter.sv | 28 ++
 rtl/latency_data_memory.sv | 126 ++++++++++++
 tb/tb_latency_data_memory.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared state encoding and sizing helper for the latency data memory family.
// Pure definitions, no logic; no handshake of its own.
package memory_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_latency_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
// Zero flag is combinational from the count; no backpressure of its own.
module mem_latency_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/latency_data_memory.sv
// Line-wide data memory with LATENCY-cycle access, byte strobes and range check.
// Response pulses LATENCY edges after acceptance; is_ready drops while busy.
module latency_data_memory
  import memory_pkg::*;
#(
  parameter int MEM_DEPTH  = 16384,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    addr_err
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = clog2(BYTES);
  localparam int INDEX_W     = ADDR_WIDTH - OFFSET_BITS;
  localparam int MIDX_W      = clog2(MEM_DEPTH);
  localparam int CNT_W       = clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]   LOAD_VAL  = CNT_W'(LATENCY - 1);
  localparam logic [INDEX_W:0]   DEPTH_LIM = (INDEX_W + 1)'(MEM_DEPTH);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_accept;
  logic                    w_cnt_zero;
  logic                    w_done;
  logic                    w_addr_err;
  logic [INDEX_W-1:0]      r_index;
  logic [DATA_WIDTH-1:0]   r_din;
  logic [BYTES-1:0]        r_wstrb;
  logic                    r_is_write;
  logic [MIDX_W-1:0]       w_idx;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];
  logic                    w_unused_ok;

  // Sub-entry byte offset never selects storage; entries are whole lines.
  assign w_unused_ok = &{1'b0, addr[OFFSET_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    is_ready     = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        is_ready = 1'b1;
        if (is_input_valid && (mem_read || mem_write)) begin
          w_accept     = 1'b1;
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (w_cnt_zero) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  mem_latency_counter #(.WIDTH(CNT_W)) u_counter (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_accept),
    .i_value (LOAD_VAL),
    .i_dec   (r_state == BUSY),
    .o_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_index    <= addr[ADDR_WIDTH-1:OFFSET_BITS];
      r_din      <= din;
      r_wstrb    <= wstrb;
      r_is_write <= mem_write;
    end
  end

  assign w_done     = (r_state == BUSY) && w_cnt_zero;
  assign w_addr_err = ({1'b0, r_index} >= DEPTH_LIM);
  assign w_idx      = r_index[MIDX_W-1:0];

  always_comb begin
    w_merged = r_mem[w_idx];
    for (int b = 0; b < BYTES; b++) begin
      if (r_wstrb[b]) w_merged[8*b +: 8] = r_din[8*b +: 8];
    end
  end

  // Writes commit on the completion edge, so a later read always sees them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
      is_output_valid <= 1'b0;
      addr_err        <= 1'b0;
      dout            <= '0;
    end else begin
      is_output_valid <= w_done;
      addr_err        <= w_done && w_addr_err;
      if (w_done) begin
        if (w_addr_err) begin
          if (!r_is_write) dout <= '0;
        end else if (r_is_write) begin
          r_mem[w_idx] <= w_merged;
        end else begin
          dout <= r_mem[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_latency_data_memory.sv
// Bench for latency_data_memory: two 32-bit LATENCY=4 instances sharing stimulus
// (deep and 16-entry) and one 128-bit LATENCY=1 instance, checked by a scoreboard.
module tb_latency_data_memory;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic         vld, rd, wr;
  logic [31:0]  addr, din;
  logic [3:0]   wstrb;
  logic         a_rdy, a_ov, a_err, b_rdy, b_ov, b_err;
  logic [31:0]  a_dout, b_dout;

  logic         c_vld, c_rd, c_wr;
  logic [31:0]  c_addr;
  logic [127:0] c_din, c_dout;
  logic [15:0]  c_wstrb;
  logic         c_rdy, c_ov, c_err;

  latency_data_memory u_dut_a (
    .clk(clk), .reset(reset), .is_input_valid(vld), .addr(addr), .din(din), .wstrb(wstrb),
    .mem_read(rd), .mem_write(wr), .is_ready(a_rdy), .is_output_valid(a_ov),
    .dout(a_dout), .addr_err(a_err));

  latency_data_memory #(.MEM_DEPTH(16)) u_dut_b (
    .clk(clk), .reset(reset), .is_input_valid(vld), .addr(addr), .din(din), .wstrb(wstrb),
    .mem_read(rd), .mem_write(wr), .is_ready(b_rdy), .is_output_valid(b_ov),
    .dout(b_dout), .addr_err(b_err));

  latency_data_memory #(.MEM_DEPTH(64), .DATA_WIDTH(128), .LATENCY(1)) u_dut_c (
    .clk(clk), .reset(reset), .is_input_valid(c_vld), .addr(c_addr), .din(c_din),
    .wstrb(c_wstrb), .mem_read(c_rd), .mem_write(c_wr), .is_ready(c_rdy),
    .is_output_valid(c_ov), .dout(c_dout), .addr_err(c_err));

  typedef struct {
    int           cyc;
    bit           is_read;
    logic [127:0] a_dout;
    bit           a_err;
    logic [127:0] b_dout;
    bit           b_err;
  } exp_t;

  exp_t q_ab[$];
  exp_t q_c[$];
  logic [127:0] model_a[int];
  logic [127:0] model_b[int];
  logic [127:0] model_c[int];

  function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                         input logic [15:0] s);
    logic [127:0] r;
    r = old;
    for (int i = 0; i < 16; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Scoreboard for the two shared-stimulus instances.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (a_ov || b_ov) begin
        checks++;
        if (q_ab.size() == 0) begin
          errors++;
          $display("FAIL ab_spurious_resp cyc=%0d a_ov=%b b_ov=%b want none", cyc, a_ov, b_ov);
        end else begin
          e = q_ab.pop_front();
          if (cyc !== e.cyc || !a_ov || !b_ov) begin
            errors++;
            $display("FAIL ab_resp_timing cyc=%0d a_ov=%b b_ov=%b want cyc=%0d both", cyc, a_ov, b_ov, e.cyc);
          end
          checks += 2;
          if (a_err !== e.a_err) begin errors++; $display("FAIL a_addr_err got %b want %b", a_err, e.a_err); end
          if (b_err !== e.b_err) begin errors++; $display("FAIL b_addr_err got %b want %b", b_err, e.b_err); end
          if (e.is_read) begin
            checks += 2;
            if (a_dout !== e.a_dout[31:0]) begin errors++; $display("FAIL a_dout got %h want %h", a_dout, e.a_dout[31:0]); end
            if (b_dout !== e.b_dout[31:0]) begin errors++; $display("FAIL b_dout got %h want %h", b_dout, e.b_dout[31:0]); end
          end
        end
      end else if (q_ab.size() > 0 && q_ab[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL ab_missing_resp cyc=%0d want response at cyc=%0d", cyc, q_ab[0].cyc);
        void'(q_ab.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (c_ov) begin
        checks++;
        if (q_c.size() == 0) begin
          errors++;
          $display("FAIL c_spurious_resp cyc=%0d want none", cyc);
        end else begin
          e = q_c.pop_front();
          checks += 2;
          if (cyc !== e.cyc) begin errors++; $display("FAIL c_resp_timing got cyc=%0d want %0d", cyc, e.cyc); end
          if (c_err !== e.a_err) begin errors++; $display("FAIL c_addr_err got %b want %b", c_err, e.a_err); end
          if (e.is_read) begin
            checks++;
            if (c_dout !== e.a_dout) begin errors++; $display("FAIL c_dout got %h want %h", c_dout, e.a_dout); end
          end
        end
      end else if (q_c.size() > 0 && q_c[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL c_missing_resp cyc=%0d want response at cyc=%0d", cyc, q_c[0].cyc);
        void'(q_c.pop_front());
      end
    end
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    q_ab.delete(); q_c.delete();
    model_a.delete(); model_b.delete(); model_c.delete();
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic issue_ab(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit r, input bit w, output int k);
    exp_t e;
    int   idx;
    vld = 1'b1; addr = a; din = d; wstrb = s; rd = r; wr = w;
    for (int t = 0; t < 50 && !a_rdy; t++) @(negedge clk);
    checks++;
    if (!a_rdy) begin errors++; $display("FAIL ab_accept_timeout a_rdy=%b want 1", a_rdy); end
    k = cyc + 1;
    idx = int'(a >> 2);
    e.cyc = k + 4; e.is_read = !w;
    e.a_err = (idx >= 16384); e.b_err = (idx >= 16);
    e.a_dout = '0; e.b_dout = '0;
    if (w) begin
      if (!e.a_err) model_a[idx] = merge(model_a.exists(idx) ? model_a[idx] : '0, {96'b0, d}, {12'b0, s});
      if (!e.b_err) model_b[idx] = merge(model_b.exists(idx) ? model_b[idx] : '0, {96'b0, d}, {12'b0, s});
    end else begin
      if (!e.a_err && model_a.exists(idx)) e.a_dout = model_a[idx];
      if (!e.b_err && model_b.exists(idx)) e.b_dout = model_b[idx];
    end
    q_ab.push_back(e);
    @(negedge clk);
  endtask

  task automatic issue_c(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                         input bit r, input bit w, output int k);
    exp_t e;
    int   idx;
    c_vld = 1'b1; c_addr = a; c_din = d; c_wstrb = s; c_rd = r; c_wr = w;
    for (int t = 0; t < 50 && !c_rdy; t++) @(negedge clk);
    checks++;
    if (!c_rdy) begin errors++; $display("FAIL c_accept_timeout c_rdy=%b want 1", c_rdy); end
    k = cyc + 1;
    idx = int'(a >> 4);
    e.cyc = k + 1; e.is_read = !w;
    e.a_err = (idx >= 64); e.b_err = 1'b0;
    e.a_dout = '0; e.b_dout = '0;
    if (w) begin
      if (!e.a_err) model_c[idx] = merge(model_c.exists(idx) ? model_c[idx] : '0, d, s);
    end else if (!e.a_err && model_c.exists(idx)) begin
      e.a_dout = model_c[idx];
    end
    q_c.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_all();
    vld = 1'b0; rd = 1'b0; wr = 1'b0;
    c_vld = 1'b0; c_rd = 1'b0; c_wr = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && (q_ab.size() > 0 || q_c.size() > 0); t++) @(negedge clk);
    checks++;
    if (q_ab.size() > 0 || q_c.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending ab=%0d c=%0d want 0", q_ab.size(), q_c.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_all();
    addr = '0; din = '0; wstrb = '0; c_addr = '0; c_din = '0; c_wstrb = '0;
    @(negedge clk);
    do_reset(3);
    checks += 5;
    if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", a_rdy, b_rdy); end
    if (a_ov !== 1'b0 || c_ov !== 1'b0) begin errors++; $display("FAIL reset_valid got %b%b want 00", a_ov, c_ov); end
    if (a_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", a_err); end
    if (a_dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", a_dout); end
    if (c_rdy !== 1'b1) begin errors++; $display("FAIL reset_c_ready got %b want 1", c_rdy); end
  endtask

  task automatic test_read_latency();
    int k;
    issue_ab(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, k);
    idle_all();
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      checks++;
      if (a_rdy !== 1'b0 || a_ov !== 1'b0) begin
        errors++;
        $display("FAIL busy_window cyc=k+%0d rdy=%b ov=%b want 0 0", j, a_rdy, a_ov);
      end
    end
    @(negedge clk);
    checks++;
    if (a_rdy !== 1'b1 || a_ov !== 1'b1) begin
      errors++;
      $display("FAIL resp_cycle cyc=k+4 rdy=%b ov=%b want 1 1", a_rdy, a_ov);
    end
    drain();
  endtask

  task automatic test_byte_strobe();
    int k;
    issue_ab(32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b1, k); idle_all(); drain();
    issue_ab(32'h10, 32'h000000AA, 4'b0001, 1'b0, 1'b1, k); idle_all(); drain();
    issue_ab(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, k); idle_all(); drain();
    checks++;
    if (a_dout !== 32'hDEADBEAA) begin errors++; $display("FAIL strobe_merge got %h want deadbeaa", a_dout); end
    issue_ab(32'h10, 32'h11111111, 4'b0000, 1'b0, 1'b1, k); idle_all(); drain();
    issue_ab(32'h10, 32'h0, 4'h0, 1'b1, 1'b0, k); idle_all(); drain();
  endtask

  task automatic test_back_to_back();
    int kw, kr;
    issue_ab(32'h20, 32'h12345678, 4'b1111, 1'b0, 1'b1, kw);
    issue_ab(32'h20, 32'h0, 4'h0, 1'b1, 1'b0, kr);
    idle_all();
    checks++;
    if (kr !== kw + 5) begin errors++; $display("FAIL b2b_accept_edge got %0d want %0d", kr, kw + 5); end
    drain();
    checks++;
    if (a_dout !== 32'h12345678) begin errors++; $display("FAIL b2b_dout got %h want 12345678", a_dout); end
  endtask

  task automatic test_out_of_range();
    int k;
    issue_ab(32'h40, 32'hFFFFFFFF, 4'b1111, 1'b0, 1'b1, k); idle_all(); drain();
    issue_ab(32'h40, 32'h0, 4'h0, 1'b1, 1'b0, k); idle_all(); drain();
    issue_ab(32'h00, 32'h0, 4'h0, 1'b1, 1'b0, k); idle_all(); drain();
    checks += 2;
    if (b_dout !== 32'h0) begin errors++; $display("FAIL oor_wrap got %h want 0", b_dout); end
    if (b_err !== 1'b0) begin errors++; $display("FAIL oor_err_idle got %b want 0", b_err); end
  endtask

  task automatic test_reset_abort();
    int k;
    issue_ab(32'h8, 32'h55, 4'b1111, 1'b0, 1'b1, k);
    idle_all();
    @(negedge clk);
    do_reset(1);
    checks++;
    if (a_rdy !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", a_rdy); end
    repeat (5) @(negedge clk);
    issue_ab(32'h8, 32'h0, 4'h0, 1'b1, 1'b0, k); idle_all(); drain();
    checks++;
    if (a_dout !== 32'h0) begin errors++; $display("FAIL abort_dout got %h want 0", a_dout); end
  endtask

  task automatic test_latency1_wide();
    int k, kr;
    logic [127:0] v;
    v = 128'h0123456789ABCDEF_FEDCBA9876543210;
    issue_c(32'h30, v, 16'hFFFF, 1'b1, 1'b1, k);
    issue_c(32'h30, '0, 16'h0, 1'b1, 1'b0, kr);
    idle_all();
    checks++;
    if (kr !== k + 2) begin errors++; $display("FAIL c_b2b_accept got %0d want %0d", kr, k + 2); end
    drain();
    checks++;
    if (c_dout !== v) begin errors++; $display("FAIL c_wide_dout got %h want %h", c_dout, v); end
    issue_c(32'h30, {128{1'b1}}, 16'h00F0, 1'b0, 1'b1, k); idle_all(); drain();
    issue_c(32'h30, '0, 16'h0, 1'b1, 1'b0, k); idle_all(); drain();
    issue_c(32'h400, v, 16'hFFFF, 1'b0, 1'b1, k); idle_all(); drain();
    issue_c(32'h400, '0, 16'h0, 1'b1, 1'b0, k); idle_all(); drain();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_latency();
    test_byte_strobe();
    test_back_to_back();
    test_out_of_range();
    test_reset_abort();
    test_latency1_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
